fetch_unit: RTL and testbench

//  Instruction fetch stage sitting directly upstream of the control unit (CU). Holds the PC,

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches words over a valid/ready request + valid response channel,
// presents them to the control unit and picks the next PC; flush redirects and drops stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] inst_pc,
    input  logic        ctl_jump,
    input  logic        ctl_jump_reg,
    input  logic        ctl_branch,
    input  logic        ctl_taken,
    input  logic [31:0] jr_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
    logic        discard_q, discard_d, mis_q, mis_d;
    logic [31:0] pc4, next_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            discard_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            discard_q <= discard_d;
            mis_q     <= mis_d;
        end
    end

    assign pc4 = inst_pc_q + 32'd4;

    always_comb begin
        next_pc = ctl_jump_reg ? {jr_target[31:2], 2'b00}
                : ctl_jump ? {pc4[31:28], inst_q[25:0], 2'b00}
                : (ctl_branch && ctl_taken) ? pc4 + {{14{inst_q[15]}}, inst_q[15:0], 2'b00}
                : pc4;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        discard_d = discard_q;
        mis_d     = mis_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: state_d = imem_req_ready ? WAIT : FETCH;
            WAIT: begin
                if (imem_rsp_valid) begin
                    discard_d = 1'b0;
                    state_d   = discard_q ? FETCH : HOLD;
                    inst_d    = discard_q ? inst_q : imem_rsp_data;
                    inst_pc_d = discard_q ? inst_pc_q : pc_q;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                    mis_d   = mis_q | (ctl_jump_reg & (|jr_target[1:0]));
                end
            end
        endcase
        // An accepted-but-unanswered request must have its response swallowed after a redirect
        if (flush && state_q != IDLE) begin
            pc_d      = {flush_pc[31:2], 2'b00};
            mis_d     = mis_q | (|flush_pc[1:0]);
            inst_d    = inst_q;
            inst_pc_d = inst_pc_q;
            state_d   = (state_q == HOLD || (state_q == WAIT && imem_rsp_valid) ||
                         (state_q == FETCH && !imem_req_ready)) ? FETCH : WAIT;
            discard_d = (state_q == FETCH && imem_req_ready) || (state_q == WAIT && !imem_rsp_valid);
        end
    end

    always_comb begin
        imem_req_valid = state_q == FETCH;
        inst_valid     = state_q == HOLD;
    end

    assign imem_addr    = pc_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign opcode       = inst_q[31:26];
    assign func         = inst_q[5:0];
    assign misalign_err = mis_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for the fetch/decode hand-off plus hand-written
// flush, stall, wrap and mid-transaction reset sequences.
module tb_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic [5:0]  opcode, func;
    logic        ctl_jump = 1'b0, ctl_jump_reg = 1'b0, ctl_branch = 1'b0, ctl_taken = 1'b0;
    logic [31:0] jr_target = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        misalign_err;
    int          checks = 0, errors = 0;

    localparam logic [31:0] ADD = 32'h0022_1820;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .opcode(opcode), .func(func), .inst_pc(inst_pc),
        .ctl_jump(ctl_jump), .ctl_jump_reg(ctl_jump_reg), .ctl_branch(ctl_branch),
        .ctl_taken(ctl_taken), .jr_target(jr_target),
        .flush(flush), .flush_pc(flush_pc), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        j, jr, br, tk;
        logic [31:0] jrt;
        logic        mis;
    } vec_t;
    vec_t v[13];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask

    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] word,
                             input logic j, input logic jr, input logic br, input logic tk,
                             input logic [31:0] jrt);
        chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("imem_addr", imem_addr, pc);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("wait_inst_valid", {31'b0, inst_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("inst", inst, word);
        chk("inst_pc", inst_pc, pc);
        chk("opcode", {26'b0, opcode}, {26'b0, word[31:26]});
        chk("func", {26'b0, func}, {26'b0, word[5:0]});
        {ctl_jump, ctl_jump_reg, ctl_branch, ctl_taken} = {j, jr, br, tk};
        jr_target  = jrt;
        inst_ready = 1'b1;
        @(negedge clk);
        {ctl_jump, ctl_jump_reg, ctl_branch, ctl_taken, inst_ready} = '0;
        jr_target = '0;
    endtask

    initial begin
        v[0]  = '{32'h0000_0000, ADD,          0, 0, 0, 0, 32'h0,   0};
        v[1]  = '{32'h0000_0004, ADD,          0, 0, 0, 0, 32'h0,   0};
        v[2]  = '{32'h0000_0008, ADD,          0, 0, 0, 0, 32'h0,   0};
        v[3]  = '{32'h0000_000C, ADD,          0, 0, 0, 0, 32'h0,   0};
        v[4]  = '{32'h0000_0010, 32'h1000_FFFC, 0, 0, 1, 1, 32'h0,   0};
        v[5]  = '{32'h0000_0004, 32'h0800_0004, 1, 0, 0, 0, 32'h0,   0};
        v[6]  = '{32'h0000_0010, 32'h1000_FFFC, 0, 0, 1, 0, 32'h0,   0};
        v[7]  = '{32'h0000_0014, 32'h0800_0040, 1, 0, 0, 0, 32'h0,   0};
        v[8]  = '{32'h0000_0100, 32'h0800_0040, 1, 0, 0, 0, 32'h0,   0};
        v[9]  = '{32'h0000_0100, 32'h03E0_0008, 0, 1, 0, 0, 32'h203, 1};
        v[10] = '{32'h0000_0200, ADD,          0, 0, 0, 0, 32'h0,   1};
        v[11] = '{32'h0000_0204, 32'h0800_0040, 1, 1, 0, 0, 32'h300, 1};
        v[12] = '{32'h0000_0300, 32'h1000_0002, 0, 0, 1, 1, 32'h0,   1};

        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 chk("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            fetch_one(v[i].pc, v[i].word, v[i].j, v[i].jr, v[i].br, v[i].tk, v[i].jrt);
            chk("misalign", {31'b0, misalign_err}, {31'b0, v[i].mis});
        end

        // flush in WAIT, stale response two cycles later
        chk("a_addr", imem_addr, 32'h0000_030C);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        flush = 1'b1;
        flush_pc = 32'h80;
        @(negedge clk);
        flush = 1'b0;
        chk("a_wait_req", {31'b0, imem_req_valid}, 32'd0);
        chk("a_wait_iv", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("a_drop_iv", {31'b0, inst_valid}, 32'd0);
        chk("a_drop_inst", inst, 32'h1000_0002);
        fetch_one(32'h80, ADD, 0, 0, 0, 0, 32'h0);

        // flush and inst_ready together in HOLD with a jump: flush wins
        chk("b_addr", imem_addr, 32'h84);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0800_0123;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        {ctl_jump, inst_ready, flush} = 3'b111;
        flush_pc = 32'h40;
        @(negedge clk);
        {ctl_jump, inst_ready, flush} = 3'b000;
        chk("b_iv", {31'b0, inst_valid}, 32'd0);
        chk("b_addr_flush", imem_addr, 32'h40);

        // stall in HOLD
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h8C00_0010;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("c_iv", {31'b0, inst_valid}, 32'd1);
            chk("c_inst", inst, 32'h8C00_0010);
            chk("c_inst_pc", inst_pc, 32'h40);
            chk("c_req", {31'b0, imem_req_valid}, 32'd0);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;

        // redirect while request unaccepted, then wrap past 0xFFFF_FFFC
        chk("d_addr", imem_addr, 32'h44);
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        flush = 1'b0;
        fetch_one(32'hFFFF_FFFC, ADD, 0, 0, 0, 0, 32'h0);
        chk("d_wrap", imem_addr, 32'h0);
        chk("d_mis_sticky", {31'b0, misalign_err}, 32'd1);

        // reset asserted in WAIT, response after release ignored, misaligned flush
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("e_req", {31'b0, imem_req_valid}, 32'd0);
        chk("e_addr", imem_addr, 32'h0);
        chk("e_iv", {31'b0, inst_valid}, 32'd0);
        chk("e_inst", inst, 32'h0);
        chk("e_inst_pc", inst_pc, 32'h0);
        chk("e_op_func", {20'b0, opcode, func}, 32'h0);
        chk("e_mis", {31'b0, misalign_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0BAD;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("e_ign_iv", {31'b0, inst_valid}, 32'd0);
        chk("e_ign_req", {31'b0, imem_req_valid}, 32'd1);
        flush = 1'b1;
        flush_pc = 32'h7;
        imem_req_ready = 1'b1;
        @(negedge clk);
        {flush, imem_req_ready} = 2'b00;
        chk("e_flush_mis", {31'b0, misalign_err}, 32'd1);
        chk("e_flush_wait", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD1_1BAD;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("e_disc_iv", {31'b0, inst_valid}, 32'd0);
        chk("e_disc_inst", inst, 32'h0);
        fetch_one(32'h4, ADD, 0, 0, 0, 0, 32'h0);
        chk("e_next", imem_addr, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
